// File: rtl/floo_id_translation_pipe_if.sv
// Request/response handshake bundle for the ID translation pipe.
// One valid/ready pair per channel on each side.
interface floo_id_translation_pipe_if #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned IdWidth     = 6,
    parameter int unsigned MaskWidth   = 4
);
    logic [NumChannels-1:0]                valid_i;
    logic [NumChannels-1:0]                ready_o;
    logic [NumChannels-1:0][AddrWidth-1:0] addr_i;
    logic [NumChannels-1:0]                valid_o;
    logic [NumChannels-1:0]                ready_i;
    logic [NumChannels-1:0][IdWidth-1:0]   id_o;
    logic [NumChannels-1:0][MaskWidth-1:0] mask_x_o;
    logic [NumChannels-1:0][MaskWidth-1:0] mask_y_o;
    logic [NumChannels-1:0]                dec_err_o;

    modport slave (
        input  valid_i, addr_i, ready_i,
        output ready_o, valid_o, id_o, mask_x_o, mask_y_o, dec_err_o
    );

    modport master (
        output valid_i, addr_i, ready_i,
        input  ready_o, valid_o, id_o, mask_x_o, mask_y_o, dec_err_o
    );
endinterface

// File: rtl/floo_id_translation_pipe.sv
// Runtime-programmable address-to-ID translator, one registered
// output slot per channel, shared rule table and error counter.
module floo_id_translation_pipe #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned NumRules    = 8,
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned IdWidth     = 6,
    parameter int unsigned MaskWidth   = 4,
    parameter bit          EnMultiCast = 1'b0,
    parameter int unsigned ErrCntWidth = 16,
    localparam int unsigned RuleWidth  =
        1 + 2 * AddrWidth + IdWidth + 2 * MaskWidth,
    localparam int unsigned IdxWidth   =
        (NumRules > 1) ? $clog2(NumRules) : 1,
    parameter logic [NumRules*RuleWidth-1:0] ResetSam = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_we_i,
    input  logic [IdxWidth-1:0]    cfg_idx_i,
    input  logic [RuleWidth-1:0]   cfg_rule_i,
    floo_id_translation_pipe_if.slave chan,
    input  logic                   err_clr_i,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    typedef struct packed {
        logic                 en;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
        logic [IdWidth-1:0]   id;
        logic [MaskWidth-1:0] mask_x;
        logic [MaskWidth-1:0] mask_y;
    } rule_t;

    localparam int unsigned IncW = $clog2(NumChannels + 1);
    localparam int unsigned SumW = ErrCntWidth + IncW;
    localparam logic [ErrCntWidth-1:0] CntMax = '1;

    rule_t [NumRules-1:0] sam_q;

    logic [NumChannels-1:0]                accept;
    logic [NumChannels-1:0][IdWidth-1:0]   lk_id;
    logic [NumChannels-1:0][MaskWidth-1:0] lk_mx;
    logic [NumChannels-1:0][MaskWidth-1:0] lk_my;
    logic [NumChannels-1:0]                lk_err;

    logic [NumChannels-1:0]                valid_q;
    logic [NumChannels-1:0][IdWidth-1:0]   id_q;
    logic [NumChannels-1:0][MaskWidth-1:0] mx_q;
    logic [NumChannels-1:0][MaskWidth-1:0] my_q;
    logic [NumChannels-1:0]                err_q;

    logic [IncW-1:0]        err_inc;
    logic [SumW-1:0]        err_sum;
    logic [ErrCntWidth-1:0] err_cnt_d;
    logic [ErrCntWidth-1:0] err_cnt_q;

    // A slot accepts when empty or when it is drained this cycle.
    assign chan.ready_o = ~valid_q | chan.ready_i;
    assign accept       = chan.valid_i & chan.ready_o;

    assign chan.valid_o   = valid_q;
    assign chan.id_o      = id_q;
    assign chan.mask_x_o  = mx_q;
    assign chan.mask_y_o  = my_q;
    assign chan.dec_err_o = err_q;
    assign err_cnt_o      = err_cnt_q;

    // Rule table; out-of-range indices match no entry and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sam_q <= ResetSam;
        end else if (cfg_we_i) begin
            for (int r = 0; r < NumRules; r++) begin
                if (cfg_idx_i == IdxWidth'(r)) begin
                    sam_q[r] <= rule_t'(cfg_rule_i);
                end
            end
        end
    end

    // Per-channel lookup; later (higher) matching rules override earlier.
    always_comb begin
        lk_id  = '0;
        lk_mx  = '0;
        lk_my  = '0;
        lk_err = '1;
        for (int c = 0; c < NumChannels; c++) begin
            for (int r = 0; r < NumRules; r++) begin
                if (sam_q[r].en &&
                    chan.addr_i[c] >= sam_q[r].start_addr &&
                    chan.addr_i[c] <  sam_q[r].end_addr) begin
                    lk_id[c]  = sam_q[r].id;
                    lk_mx[c]  = EnMultiCast ? sam_q[r].mask_x : '0;
                    lk_my[c]  = EnMultiCast ? sam_q[r].mask_y : '0;
                    lk_err[c] = 1'b0;
                end
            end
        end
    end

    // Output slots: load on accept, empty when drained without refill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            id_q    <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            err_q   <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (accept[c]) begin
                    valid_q[c] <= 1'b1;
                    id_q[c]    <= lk_id[c];
                    mx_q[c]    <= lk_mx[c];
                    my_q[c]    <= lk_my[c];
                    err_q[c]   <= lk_err[c];
                end else if (chan.ready_i[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
        end
    end

    // Next error count: clear replaces the base, then saturating add.
    always_comb begin
        err_inc = '0;
        for (int c = 0; c < NumChannels; c++) begin
            err_inc = err_inc + IncW'(accept[c] & lk_err[c]);
        end
        err_sum = (err_clr_i ? SumW'(0) : SumW'(err_cnt_q))
                + SumW'(err_inc);
        err_cnt_d = (err_sum > SumW'(CntMax))
                  ? CntMax : err_sum[ErrCntWidth-1:0];
    end

    // Error counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_floo_id_translation_pipe.sv
// Scoreboard bench: two DUTs (multicast on / 16-bit counter and
// multicast off / 2-bit counter) share stimulus and a rule model.
module tb_floo_id_translation_pipe;

    localparam int RW = 111;
    localparam logic [RW-1:0] R0 =
        {1'b1, 48'h1000, 48'h2000, 6'd3, 4'h0, 4'h0};
    localparam logic [8*RW-1:0] SAM = {{(7*RW){1'b0}}, R0};

    typedef struct {
        bit              en;
        longint unsigned st;
        longint unsigned ed;
        int              id;
        int              mx;
        int              my;
    } mrule_t;

    typedef struct {
        int id;
        int mx;
        int my;
        bit err;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    logic cfg_we = 0;
    logic [2:0] cfg_idx = '0;
    logic [RW-1:0] cfg_rule = '0;
    logic err_clr = 0;
    logic [15:0] err_cnt_a;
    logic [1:0]  err_cnt_b;

    floo_id_translation_pipe_if ifa ();
    floo_id_translation_pipe_if ifb ();

    floo_id_translation_pipe #(
        .EnMultiCast (1'b1),
        .ResetSam    (SAM)
    ) dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_rule_i (cfg_rule),
        .chan       (ifa),
        .err_clr_i  (err_clr),
        .err_cnt_o  (err_cnt_a)
    );

    floo_id_translation_pipe #(
        .EnMultiCast (1'b0),
        .ErrCntWidth (2),
        .ResetSam    (SAM)
    ) dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_rule_i (cfg_rule),
        .chan       (ifb),
        .err_clr_i  (err_clr),
        .err_cnt_o  (err_cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mrule_t tbl [8];
    exp_t   sbq [2][$];
    bit     full [2];
    longint cnt_a;
    longint cnt_b;

    bit     we;
    int     widx;
    mrule_t wrule;
    bit     clr;

    task automatic chk(input string n, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack(input mrule_t r);
        return {r.en, 48'(r.st), 48'(r.ed), 6'(r.id), 4'(r.mx), 4'(r.my)};
    endfunction

    // Highest-numbered enabled rule whose [st, ed) holds the address.
    function automatic exp_t lookup(input longint unsigned a);
        exp_t e;
        e = '{id: 0, mx: 0, my: 0, err: 1'b1};
        for (int r = 7; r >= 0; r--) begin
            if (tbl[r].en && a >= tbl[r].st && a < tbl[r].ed) begin
                e = '{id: tbl[r].id, mx: tbl[r].mx, my: tbl[r].my, err: 1'b0};
                break;
            end
        end
        return e;
    endfunction

    function automatic mrule_t mk(input bit en, input longint unsigned st,
                                  input longint unsigned ed, input int id,
                                  input int mx, input int my);
        mrule_t r;
        r = '{en: en, st: st, ed: ed, id: id, mx: mx, my: my};
        return r;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) tbl[r] = mk(0, 0, 0, 0, 0, 0);
        tbl[0] = mk(1, 'h1000, 'h2000, 3, 0, 0);
        sbq[0].delete();
        sbq[1].delete();
        full[0] = 0;
        full[1] = 0;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    // One cycle of stimulus, entered and left on a falling edge.
    task automatic step(input bit v0, input bit v1,
                        input logic [47:0] a0, input logic [47:0] a1,
                        input bit r0, input bit r1);
        bit v [2];
        bit rr [2];
        logic [47:0] a [2];
        longint inc;
        bit rdy;
        exp_t e;
        v[0] = v0; v[1] = v1;
        rr[0] = r0; rr[1] = r1;
        a[0] = a0; a[1] = a1;
        chk("valid_o", 64'(ifa.valid_o), {62'd0, full[1], full[0]});
        chk("valid_o_b", 64'(ifb.valid_o), {62'd0, full[1], full[0]});
        chk("err_cnt_a", 64'(err_cnt_a), cnt_a);
        chk("err_cnt_b", 64'(err_cnt_b), cnt_b);
        for (int c = 0; c < 2; c++) begin
            ifa.valid_i[c] = v[c];
            ifb.valid_i[c] = v[c];
            ifa.addr_i[c]  = a[c];
            ifb.addr_i[c]  = a[c];
            ifa.ready_i[c] = rr[c];
            ifb.ready_i[c] = rr[c];
        end
        cfg_we   = we;
        cfg_idx  = 3'(widx);
        cfg_rule = pack(wrule);
        err_clr  = clr;
        #1;
        inc = 0;
        for (int c = 0; c < 2; c++) begin
            rdy = !full[c] || rr[c];
            chk("ready_o", 64'(ifa.ready_o[c]), 64'(rdy));
            chk("ready_o_b", 64'(ifb.ready_o[c]), 64'(rdy));
            if (v[c] && rdy) begin
                e = lookup(a[c]);
                sbq[c].push_back(e);
                inc += e.err;
            end
            full[c] = (v[c] && rdy) || (full[c] && !rr[c]);
        end
        cnt_a = clr ? inc : cnt_a + inc;
        if (cnt_a > 65535) cnt_a = 65535;
        cnt_b = clr ? inc : cnt_b + inc;
        if (cnt_b > 3) cnt_b = 3;
        if (we && widx < 8) tbl[widx] = wrule;
        we  = 0;
        clr = 0;
        @(negedge clk);
    endtask

    task automatic cfg(input int idx, input mrule_t r);
        we = 1;
        widx = idx;
        wrule = r;
    endtask

    // Monitor: the head of each channel queue must be on the outputs
    // whenever valid_o is high; it retires when ready_i completes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int c = 0; c < 2; c++) begin
                    if (ifa.valid_o[c]) begin
                        if (sbq[c].size() == 0) begin
                            chk("unexpected_out", 1, 0);
                        end else begin
                            e = sbq[c][0];
                            chk("id_a", 64'(ifa.id_o[c]), 64'(e.id));
                            chk("mx_a", 64'(ifa.mask_x_o[c]), 64'(e.mx));
                            chk("my_a", 64'(ifa.mask_y_o[c]), 64'(e.my));
                            chk("err_a", 64'(ifa.dec_err_o[c]), 64'(e.err));
                            chk("id_b", 64'(ifb.id_o[c]), 64'(e.id));
                            chk("mx_b", 64'(ifb.mask_x_o[c]), 0);
                            chk("my_b", 64'(ifb.mask_y_o[c]), 0);
                            chk("err_b", 64'(ifb.dec_err_o[c]), 64'(e.err));
                            if (ifa.ready_i[c]) void'(sbq[c].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [47:0] ra0, ra1;
        we = 0; widx = 0; clr = 0;
        wrule = mk(0, 0, 0, 0, 0, 0);
        model_reset();
        ifa.valid_i = '0; ifb.valid_i = '0;
        ifa.addr_i  = '0; ifb.addr_i  = '0;
        ifa.ready_i = '0; ifb.ready_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready_o", 64'(ifa.ready_o), 3);
        chk("rst_valid_o", 64'(ifa.valid_o), 0);
        chk("rst_id_o", 64'(ifa.id_o), 0);
        chk("rst_err_cnt", 64'(err_cnt_a), 0);
        rst_n = 1;

        // Reset table hit, then a write racing a lookup.
        step(1, 0, 48'h1800, 0, 1, 1);
        cfg(0, mk(1, 'h1000, 'h2000, 9, 0, 0));
        step(1, 0, 48'h1800, 0, 1, 1);
        step(1, 0, 48'h1800, 0, 1, 1);

        // Overlapping rules and exclusive end.
        cfg(1, mk(1, 'h0, 'h10000, 5, 0, 0));
        step(0, 0, 0, 0, 1, 1);
        cfg(2, mk(1, 'h1000, 'h2000, 7, 0, 0));
        step(0, 0, 0, 0, 1, 1);
        step(1, 1, 48'h1000, 48'h2000, 1, 1);
        step(1, 0, 48'h20000, 0, 1, 1);
        step(1, 1, 48'h20000, 48'h30000, 1, 1);
        clr = 1;
        step(1, 1, 48'h1800, 48'h30000, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Backpressure on ch0 while ch1 streams.
        step(1, 1, 48'h1000, 48'h0100, 0, 1);
        step(1, 1, 48'h1800, 48'h0200, 0, 1);
        step(1, 1, 48'h1800, 48'h0300, 0, 1);
        step(1, 1, 48'h1800, 48'h0400, 0, 1);
        step(1, 0, 48'h2000, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Multicast fields.
        cfg(3, mk(1, 'h30000, 'h40000, 11, 5, 2));
        step(0, 0, 0, 0, 1, 1);
        step(1, 1, 48'h38000, 48'h3FFFF, 1, 1);

        // Saturation of the narrow counter.
        clr = 1;
        step(1, 1, 48'h90000, 48'h90000, 1, 1);
        step(1, 1, 48'h90000, 48'h90000, 1, 1);
        step(1, 0, 48'h90000, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Randomized traffic, ready patterns, table rewrites and clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg($urandom_range(0, 7),
                    mk($urandom_range(0, 3) != 0,
                       $urandom_range(0, 'h4FFFF),
                       $urandom_range(0, 'h4FFFF),
                       $urandom_range(0, 63),
                       $urandom_range(0, 15),
                       $urandom_range(0, 15)));
            end
            clr = ($urandom_range(0, 15) == 0);
            ra0 = 48'($urandom_range(0, 'h4FFFF));
            ra1 = 48'($urandom_range(0, 'h4FFFF));
            if ($urandom_range(0, 15) == 0) ra1[47] = 1'b1;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 ra0, ra1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end

        // Drain and confirm everything issued came out.
        repeat (3) step(0, 0, 0, 0, 1, 1);
        chk("drain_q0", 64'(sbq[0].size()), 0);
        chk("drain_q1", 64'(sbq[1].size()), 0);

        // Reset with a held result discards it and restores the table.
        step(1, 1, 48'h1800, 48'h90000, 0, 0);
        rst_n = 0;
        model_reset();
        #1;
        chk("mid_rst_valid_o", 64'(ifa.valid_o), 0);
        chk("mid_rst_ready_o", 64'(ifa.ready_o), 3);
        chk("mid_rst_err_cnt", 64'(err_cnt_a), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 0, 48'h1800, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0, 1, 1);
        chk("final_q0", 64'(sbq[0].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
